menu_compositor: RTL and testbench

//  Parametrised, registered screen compositor for the menu/game/game-over path. Picks one of
//  N_SCREENS overlay layers per pixel (layer if valid, else background) from the FSM screen code.

---
 rtl/menu_pkg.sv | 7 +
 rtl/rgb_blend.sv | 19 +
 rtl/menu_compositor.sv | 108 ++++++++++
 tb/tb_menu_compositor.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/menu_pkg.sv
// menu_pkg: shared pixel type, screen codes and compositor FSM states
package menu_pkg;
    localparam int DEF_RGB_W = 12;
    typedef logic [DEF_RGB_W-1:0] rgb_t;
    typedef enum logic [1:0] {SCR_START = 2'd0, SCR_GAME = 2'd1, SCR_OVER = 2'd2} screen_e;
    typedef enum logic {IDLE, FADE} comp_state_e;
endpackage

// File: rtl/rgb_blend.sv
// rgb_blend: per-channel linear mix out = (old*(K-alpha) + new*alpha) >> FADE_LOG2
// Ports: old_i/new_i 3-channel pixels, alpha_i fade step, out_o blended pixel (combinational).
module rgb_blend #(
    parameter int CW        = 4,
    parameter int FADE_LOG2 = 4
) (
    input  logic [3*CW-1:0]      old_i,
    input  logic [3*CW-1:0]      new_i,
    input  logic [FADE_LOG2-1:0] alpha_i,
    output logic [3*CW-1:0]      out_o
);
    localparam int W = CW + FADE_LOG2 + 1;
    localparam int K = 2 ** FADE_LOG2;
    for (genvar c = 0; c < 3; c++) begin : g_ch
        logic [W-1:0] mix;
        assign mix = W'(old_i[c*CW +: CW]) * (W'(K) - W'(alpha_i)) + W'(new_i[c*CW +: CW]) * W'(alpha_i);
        assign out_o[c*CW +: CW] = CW'(mix >> FADE_LOG2);
    end
endmodule

// File: rtl/menu_compositor.sv
// menu_compositor: frame-synchronous screen compositor, optional cross-fade when MENU_COMP_FADE_EN is defined
// Ports: clk, rst_n (async active-low); state_i screen code; frame_start_i vblank pulse;
//   rgb_bg_i, rgb_layer_i, valid_layer_i, blank_i pixel inputs; rgb_out_o, blank_out_o (2 clk later);
//   cur_sel_o displayed screen code; busy_o fade in progress.
module menu_compositor
    import menu_pkg::*;
#(
    parameter int N_SCREENS = 3,
    parameter int SEL_W     = 2,
    parameter int RGB_W     = DEF_RGB_W,
    parameter int FADE_LOG2 = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [SEL_W-1:0]           state_i,
    input  logic                       frame_start_i,
    input  logic [RGB_W-1:0]           rgb_bg_i,
    input  logic [N_SCREENS*RGB_W-1:0] rgb_layer_i,
    input  logic [N_SCREENS-1:0]       valid_layer_i,
    input  logic                       blank_i,
    output logic [RGB_W-1:0]           rgb_out_o,
    output logic                       blank_out_o,
    output logic [SEL_W-1:0]           cur_sel_o,
    output logic                       busy_o
);
    logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
    logic [RGB_W-1:0] pix_new_q, rgb_out_q, rgb_out_d;
    logic             blank1_q, blank_out_q;

    // Out-of-range codes and invalid layer pixels fall back to the background.
    function automatic logic [RGB_W-1:0] pick(input logic [SEL_W-1:0] s);
        return (int'(s) < N_SCREENS && valid_layer_i[s]) ? rgb_layer_i[int'(s)*RGB_W +: RGB_W] : rgb_bg_i;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_sel_q   <= '0;
            pix_new_q   <= '0;
            blank1_q    <= 1'b1;
            rgb_out_q   <= '0;
            blank_out_q <= 1'b1;
        end else begin
            cur_sel_q   <= cur_sel_d;
            pix_new_q   <= pick(cur_sel_q);
            blank1_q    <= blank_i;
            rgb_out_q   <= rgb_out_d;
            blank_out_q <= blank1_q;
        end
    end

`ifdef MENU_COMP_FADE_EN
    comp_state_e            st_q, st_d;
    logic [FADE_LOG2-1:0]   alpha_q, alpha_d;
    logic [SEL_W-1:0]       prev_sel_q, prev_sel_d;
    logic [RGB_W-1:0]       pix_old_q, blend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= IDLE;
            alpha_q    <= '0;
            prev_sel_q <= '0;
            pix_old_q  <= '0;
        end else begin
            st_q       <= st_d;
            alpha_q    <= alpha_d;
            prev_sel_q <= prev_sel_d;
            pix_old_q  <= pick(prev_sel_q);
        end
    end

    // Screen requests are sampled only at frame_start and only while idle, so fades never chain or abort.
    always_comb begin
        st_d       = st_q;
        alpha_d    = alpha_q;
        prev_sel_d = prev_sel_q;
        cur_sel_d  = cur_sel_q;
        if (frame_start_i && st_q == IDLE && state_i != cur_sel_q) begin
            prev_sel_d = cur_sel_q;
            cur_sel_d  = state_i;
            alpha_d    = '0;
            st_d       = FADE;
        end else if (frame_start_i && st_q == FADE) begin
            alpha_d    = alpha_q + 1'b1;
            st_d       = &alpha_q ? IDLE : FADE;
            prev_sel_d = &alpha_q ? cur_sel_q : prev_sel_q;
        end
    end

    rgb_blend #(.CW(RGB_W / 3), .FADE_LOG2(FADE_LOG2)) u_blend (
        .old_i   (pix_old_q),
        .new_i   (pix_new_q),
        .alpha_i (alpha_q),
        .out_o   (blend)
    );

    // State/alpha change during vblank, so the blanked frame_start pixel hides the one-cycle skew.
    assign rgb_out_d = blank1_q ? '0 : (st_q == FADE ? blend : pix_new_q);
    assign busy_o    = (st_q == FADE);
`else
    assign cur_sel_d = frame_start_i ? state_i : cur_sel_q;
    assign rgb_out_d = blank1_q ? '0 : pix_new_q;
    assign busy_o    = 1'b0;
`endif

    assign rgb_out_o   = rgb_out_q;
    assign blank_out_o = blank_out_q;
    assign cur_sel_o   = cur_sel_q;
endmodule

// File: tb/tb_menu_compositor.sv
// tb_menu_compositor: randomized scoreboard bench for menu_compositor (both fade builds)
module tb_menu_compositor;
    import menu_pkg::*;
    localparam int FL = 16;
    localparam int K  = 4;
`ifdef MENU_COMP_FADE_EN
    localparam bit FADE = 1'b1;
`else
    localparam bit FADE = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, fs = 1'b0, bl = 1'b1;
    logic [1:0]  state = '0;
    rgb_t        bg = '0;
    logic [35:0] lay = '0;
    logic [2:0]  vl = '0;
    rgb_t        rgb_out;
    logic        blank_out, busy;
    logic [1:0]  cur_sel;

    always #5 clk = ~clk;

    menu_compositor #(.N_SCREENS(3), .SEL_W(2), .RGB_W(12), .FADE_LOG2(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .state_i       (state),
        .frame_start_i (fs),
        .rgb_bg_i      (bg),
        .rgb_layer_i   (lay),
        .valid_layer_i (vl),
        .blank_i       (bl),
        .rgb_out_o     (rgb_out),
        .blank_out_o   (blank_out),
        .cur_sel_o     (cur_sel),
        .busy_o        (busy)
    );

    typedef struct {rgb_t rgb; logic blank; logic [1:0] cur; logic busy;} exp_t;
    exp_t        sb[$];
    int          checks = 0, errors = 0;
    bit          mon_en = 1'b0;
    logic [1:0]  m_cur = '0, m_prev = '0;
    int          m_a = 0;
    bit          m_fade = 1'b0;
    rgb_t        fx_bg = '0;
    logic [35:0] fx_lay = '0;
    logic [2:0]  fx_vl = '0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rgb_t layer_pix(logic [1:0] s);
        return (int'(s) < 3 && vl[s]) ? lay[int'(s)*12 +: 12] : bg;
    endfunction

    function automatic rgb_t mix(rgb_t o, rgb_t n, int a);
        rgb_t r;
        for (int c = 0; c < 3; c++)
            r[c*4 +: 4] = 4'((int'(o[c*4 +: 4]) * (K - a) + int'(n[c*4 +: 4]) * a) / K);
        return r;
    endfunction

    // Drive one pixel cycle and record what the screen should show for it.
    task automatic drive(logic f, logic [1:0] s, rgb_t b, logic [35:0] l, logic [2:0] v, logic bk);
        exp_t e;
        @(negedge clk);
        fs = f; state = s; bg = b; lay = l; vl = v; bl = bk;
        e.rgb   = bk ? '0 : (m_fade ? mix(layer_pix(m_prev), layer_pix(m_cur), m_a) : layer_pix(m_cur));
        e.blank = bk;
        if (f) begin
            if (m_fade) begin
                if (m_a == K - 1) m_fade = 1'b0;
                else m_a++;
            end else if (s != m_cur) begin
                m_prev = m_cur;
                m_cur  = s;
                m_fade = FADE;
                m_a    = 0;
            end
        end
        e.cur  = m_cur;
        e.busy = m_fade;
        sb.push_back(e);
    endtask

    task automatic run_frame(logic [1:0] s0, logic [1:0] s1, bit rnd);
        for (int c = 0; c < FL; c++) begin
            if (rnd)
                drive(c == 0, c < FL/2 ? s0 : s1, rgb_t'($urandom), 36'({$urandom, $urandom}),
                      3'($urandom), c < 3 || ($urandom_range(0, 7) == 0));
            else
                drive(c == 0, c < FL/2 ? s0 : s1, fx_bg, fx_lay, fx_vl, c < 3);
        end
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        fs = 1'b0;
        #1;
        check("rst_rgb", rgb_out, 0);
        check("rst_blank", blank_out, 1);
        check("rst_cur", cur_sel, 0);
        check("rst_busy", busy, 0);
        sb.delete();
        m_cur = '0; m_prev = '0; m_a = 0; m_fade = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    // Output at edge p reflects inputs captured at p-1; cur_sel/busy reflect the decision at p.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (mon_en && sb.size() >= 2) begin
            e = sb.pop_front();
            check("sb_rgb", rgb_out, e.rgb);
            check("sb_blank", blank_out, e.blank);
            check("sb_cur", cur_sel, sb[0].cur);
            check("sb_busy", busy, sb[0].busy);
        end
    end

    initial begin
        rgb_t fv [5];
        logic [1:0] s0 [5], s1 [5];
        fv = '{12'h000, 12'h333, 12'h777, 12'hBBB, 12'hFFF};
        do_reset();

        fx_bg = 12'h00F; fx_lay = {12'h000, 12'hF00, 12'h000}; fx_vl = 3'b010;
        repeat (K + 2) run_frame(2'd1, 2'd1, 1'b0);
        check("sel1_cur", cur_sel, 1);
        check("sel1_layer", rgb_out, 12'hF00);
        fx_vl = 3'b000;
        run_frame(2'd1, 2'd1, 1'b0);
        check("bg_fallback", rgb_out, 12'h00F);

        fx_vl = 3'b111; fx_lay = {12'h0C0, 12'hF00, 12'h00A};
        repeat (K + 2) run_frame(2'd0, 2'd0, 1'b0);
        run_frame(2'd0, 2'd2, 1'b0);
        check("midframe_hold", cur_sel, 0);
        run_frame(2'd2, 2'd2, 1'b0);
        check("frame_switch", cur_sel, 2);

        repeat (K + 2) run_frame(2'd3, 2'd3, 1'b0);
        check("oor_bg", rgb_out, 12'h00F);

        fx_bg = 12'h123; fx_lay = {12'h000, 12'hFFF, 12'h000}; fx_vl = 3'b011;
        repeat (K + 2) run_frame(2'd0, 2'd0, 1'b0);
        s0 = '{2'd1, 2'd1, FADE ? 2'd2 : 2'd1, 2'd1, 2'd1};
        s1 = '{2'd1, FADE ? 2'd2 : 2'd1, FADE ? 2'd2 : 2'd1, 2'd1, 2'd1};
        for (int i = 0; i < 5; i++) begin
            run_frame(s0[i], s1[i], 1'b0);
            check("fade_rgb", rgb_out, FADE ? fv[i] : 12'hFFF);
            check("fade_busy", busy, FADE && i < 4);
            check("fade_cur", cur_sel, 1);
        end

        fx_lay = {12'h000, 12'hFFF, 12'h0A5}; fx_vl = 3'b111;
        repeat (K + 2) run_frame(2'd0, 2'd0, 1'b0);
        repeat (2) run_frame(2'd1, 2'd1, 1'b0);
        for (int c = 0; c < FL/2; c++) drive(c == 0, 2'd1, fx_bg, fx_lay, fx_vl, c < 3);
        do_reset();
        run_frame(2'd0, 2'd0, 1'b0);
        check("post_rst_rgb", rgb_out, 12'h0A5);
        check("post_rst_busy", busy, 0);
        check("post_rst_cur", cur_sel, 0);

        repeat (40) run_frame(2'($urandom), 2'($urandom), 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
